// File: rtl/cordic_rotation_engine.sv
`timescale 1ns/1ps
// Iterative rotation-mode CORDIC. Rotates (x,y) by angle z (radians,
// Q(WIDTH-ANGLE_FRAC).ANGLE_FRAC), one micro-rotation per clock, with a
// quadrant pre-rotation so the full [-pi, +pi] range converges. The CORDIC
// gain K is left uncompensated; one vector is in flight at a time.
module cordic_rotation_engine #(
  parameter int WIDTH      = 32,
  parameter int ITERATIONS = 16,
  parameter int ANGLE_FRAC = 29
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] z_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out
);

  localparam int IW = $clog2(ITERATIONS + 1);

  typedef enum logic [1:0] {IDLE, PREROT, ITER, DONE} state_t;

  // Angle constants are tabulated with 29 fractional bits and rescaled to
  // ANGLE_FRAC with round-half-up, so the table serves any angle format.
  function automatic logic signed [WIDTH-1:0] scale_angle(input logic signed [63:0] q29);
    logic signed [63:0] r;
    int sh;
    sh = 29 - ANGLE_FRAC;
    if (sh > 0) r = (q29 + (64'sd1 <<< (sh - 1))) >>> sh;
    else        r = q29 <<< (-sh);
    return WIDTH'(r);
  endfunction

  // round(atan(2^-i) * 2^29); beyond i=10 atan(2^-i) equals 2^-i to within
  // half an LSB at this precision.
  function automatic logic signed [63:0] atan_q29(input int i);
    case (i)
      0:       return 64'sd421657428;
      1:       return 64'sd248918915;
      2:       return 64'sd131521918;
      3:       return 64'sd66762579;
      4:       return 64'sd33510843;
      5:       return 64'sd16771758;
      6:       return 64'sd8387925;
      7:       return 64'sd4194219;
      8:       return 64'sd2097141;
      9:       return 64'sd1048575;
      10:      return 64'sd524288;
      default: return (i <= 29) ? (64'sd1 <<< (29 - i)) : 64'sd0;
    endcase
  endfunction

  localparam logic signed [WIDTH-1:0] HALF_PI     = scale_angle(64'sd843314857);
  localparam logic signed [WIDTH-1:0] NEG_HALF_PI = -HALF_PI;

  state_t                  state_q, state_d;
  logic signed [WIDTH-1:0] x_q, y_q, z_q;
  logic signed [WIDTH-1:0] x_d, y_d, z_d;
  logic [IW-1:0]           iter_q, iter_d;
  logic signed [WIDTH-1:0] x_out_d, y_out_d;
  logic                    out_valid_d;
  logic signed [WIDTH-1:0] x_sh, y_sh, ang;

  assign in_ready = (state_q == IDLE);

  // Next-state and datapath: accept, quadrant fold, micro-rotations, handoff.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    iter_d      = iter_q;
    x_out_d     = x_out;
    y_out_d     = y_out;
    out_valid_d = out_valid;
    x_sh        = x_q >>> iter_q;
    y_sh        = y_q >>> iter_q;
    ang         = scale_angle(atan_q29(int'(iter_q)));
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = x_in;
          y_d     = y_in;
          z_d     = z_in;
          iter_d  = '0;
          state_d = PREROT;
        end
      end
      PREROT: begin
        // Fold |z| > pi/2 by an exact +/-90 degree swap so the iterative
        // stage only sees angles inside its convergence range.
        if (z_q > HALF_PI) begin
          x_d = -y_q;
          y_d = x_q;
          z_d = z_q - HALF_PI;
        end else if (z_q < NEG_HALF_PI) begin
          x_d = y_q;
          y_d = -x_q;
          z_d = z_q + HALF_PI;
        end
        state_d = ITER;
      end
      ITER: begin
        if (!z_q[WIDTH-1]) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - ang;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + ang;
        end
        iter_d = iter_q + 1'b1;
        if (iter_q == IW'(ITERATIONS - 1)) begin
          x_out_d     = x_d;
          y_out_d     = y_d;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        // in_valid is deliberately ignored here; a new vector needs IDLE.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, working registers and result registers; reset aborts any vector.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      iter_q    <= '0;
      x_out     <= '0;
      y_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      iter_q    <= iter_d;
      x_out     <= x_out_d;
      y_out     <= y_out_d;
      out_valid <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_cordic_rotation_engine.sv
`timescale 1ns/1ps
// Scoreboard bench for cordic_rotation_engine: the driver pushes expected
// results, an independent monitor pops and compares on each output handshake.
module tb_cordic_rotation_engine;

  localparam int  WIDTH      = 32;
  localparam int  ITERATIONS = 16;
  localparam int  ANGLE_FRAC = 29;
  localparam real K          = 1.6467602581210654;

  logic                    clock = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic signed [WIDTH-1:0] x_in = '0;
  logic signed [WIDTH-1:0] y_in = '0;
  logic signed [WIDTH-1:0] z_in = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic signed [WIDTH-1:0] x_out;
  logic signed [WIDTH-1:0] y_out;

  typedef struct {
    longint ex;
    longint ey;
    longint tol;
  } exp_t;

  exp_t sb[$];
  int   n_total  = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   last_pop = -1;
  bit   tp_mode  = 1'b0;

  cordic_rotation_engine #(
    .WIDTH(WIDTH), .ITERATIONS(ITERATIONS), .ANGLE_FRAC(ANGLE_FRAC)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok, input longint act, input longint req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic longint absl(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  // Allowance = residual angle after the last micro-rotation (atan(2^-(N-1)))
  // applied to the output magnitude, plus 16 LSB for shift truncation.
  function automatic longint tol_for(input longint x, input longint y);
    real mag;
    mag = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
    return 64'sd16 + longint'($ceil(K * mag * $atan(2.0 ** (-(ITERATIONS - 1)))));
  endfunction

  function automatic exp_t model(input longint x, input longint y, input longint z);
    exp_t e;
    real  a;
    a    = real'(z) / (2.0 ** ANGLE_FRAC);
    e.ex = longint'(K * (real'(x) * $cos(a) - real'(y) * $sin(a)));
    e.ey = longint'(K * (real'(x) * $sin(a) + real'(y) * $cos(a)));
    e.tol = tol_for(x, y);
    return e;
  endfunction

  // Called just after a rising edge; returns 1ns after the accepting edge.
  task automatic send(input longint x, input longint y, input longint z,
                      input exp_t e, input bit expect_out);
    int w;
    w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clock); #1;
      w++;
    end
    if (!in_ready) begin
      check("send_ready_timeout", 1'b0, 0, 1);
      return;
    end
    x_in     = WIDTH'(x);
    y_in     = WIDTH'(y);
    z_in     = WIDTH'(z);
    in_valid = 1'b1;
    if (expect_out) sb.push_back(e);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clock); #1;
      w++;
    end
    if (!in_ready) check("idle_timeout", 1'b0, 0, 1);
  endtask

  // Monitor: compare every presented-and-taken result against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 1'b0, longint'(x_out), 0);
        end else begin
          e = sb.pop_front();
          check("x_out", absl(longint'(x_out) - e.ex) <= e.tol, longint'(x_out), e.ex);
          check("y_out", absl(longint'(y_out) - e.ey) <= e.tol, longint'(y_out), e.ey);
        end
        if (tp_mode) begin
          if (last_pop >= 0) check("result_spacing", (cyc - last_pop) == 19, cyc - last_pop, 19);
          last_pop = cyc;
        end
      end
    end
  end

  initial begin
    int            n;
    logic signed [WIDTH-1:0] hx, hy;
    longint        rx, ry, rz;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_in_ready", in_ready == 1'b1, in_ready, 1);
    check("rst_out_valid", out_valid == 1'b0, out_valid, 0);
    check("rst_x_out", x_out == 0, x_out, 0);
    check("rst_y_out", y_out == 0, y_out, 0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // z=0: pure gain, and latency from accept to out_valid
    send(64'sd1 <<< 20, 0, 0, '{64'sd1726753, 64'sd0, tol_for(64'sd1 <<< 20, 0)}, 1'b1);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    check("latency", n == 17, n, 17);

    // +pi/2 (boundary of the fold), -pi and +pi (both fold branches)
    send(64'sd1 <<< 20, 0, 64'sd843314857, '{64'sd0, 64'sd1726753, tol_for(64'sd1 <<< 20, 0)}, 1'b1);
    send(64'sd1 <<< 20, 0, -64'sd1686629713, '{-64'sd1726753, 64'sd0, tol_for(64'sd1 <<< 20, 0)}, 1'b1);
    send(0, 64'sd1 <<< 20, 64'sd1686629713, '{64'sd0, -64'sd1726753, tol_for(0, 64'sd1 <<< 20)}, 1'b1);
    // Mixed-sign vectors through each fold branch
    send(64'sd1 <<< 18, -(64'sd1 <<< 18), 64'sd1000000000,
         model(64'sd1 <<< 18, -(64'sd1 <<< 18), 64'sd1000000000), 1'b1);
    send(-(64'sd1 <<< 19), 64'sd1 <<< 17, -64'sd1200000000,
         model(-(64'sd1 <<< 19), 64'sd1 <<< 17, -64'sd1200000000), 1'b1);

    // Back-pressure: result held, input ignored while DONE
    wait_ready();
    out_ready = 1'b0;
    send(64'sd300000, 64'sd200000, 64'sd400000000,
         model(64'sd300000, 64'sd200000, 64'sd400000000), 1'b1);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    check("hold_out_valid_seen", out_valid == 1'b1, out_valid, 1);
    hx = x_out;
    hy = y_out;
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      x_in     = $urandom;
      z_in     = $urandom;
      @(posedge clock); #1;
      check("hold_out_valid", out_valid == 1'b1, out_valid, 1);
      check("hold_in_ready", in_ready == 1'b0, in_ready, 0);
      check("hold_x_out", x_out == hx, x_out, hx);
      check("hold_y_out", y_out == hy, y_out, hy);
    end
    // Output handshake with a simultaneous in_valid: only the handshake happens
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("release_in_ready", in_ready == 1'b1, in_ready, 1);
    check("release_out_valid", out_valid == 1'b0, out_valid, 0);
    @(posedge clock); #1;
    check("no_accept_from_done", in_ready == 1'b1, in_ready, 1);

    // Asynchronous reset in the middle of the iterations (i=5)
    send(64'sd500000, -64'sd100000, 64'sd700000000, '{0, 0, 0}, 1'b0);
    repeat (6) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid == 1'b0, out_valid, 0);
    check("abort_in_ready", in_ready == 1'b1, in_ready, 1);
    check("abort_x_out", x_out == 0, x_out, 0);
    check("abort_y_out", y_out == 0, y_out, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    send(64'sd400000, 64'sd250000, -64'sd900000000,
         model(64'sd400000, 64'sd250000, -64'sd900000000), 1'b1);

    // Back-to-back random vectors with out_ready held high
    wait_ready();
    tp_mode  = 1'b1;
    last_pop = -1;
    for (int i = 0; i < 20; i++) begin
      rx = longint'($urandom_range(0, 32768)) - 64'sd16384;
      ry = longint'($urandom_range(0, 32768)) - 64'sd16384;
      rz = longint'($urandom_range(0, 32'd3373259424)) - 64'sd1686629712;
      send(rx, ry, rz, model(rx, ry, rz), 1'b1);
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    tp_mode = 1'b0;
    repeat (25) @(posedge clock);
    #1;
    check("scoreboard_drained", sb.size() == 0, sb.size(), 0);
    check("final_out_valid", out_valid == 1'b0, out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
